lieat_exu_trap_ctrl: RTL

Parametrised trap and interrupt controller for the EXU commit stage, the successor to the single-timer/single-software-interrupt CSR unit. It owns the machine trap CSRs (mstatus, mie, mip, mtvec, mepc, mcause) and arbitrates `NUM_IRQ` level-sensitive interrupt lines by fixed priority. Asynchronous interrupts are taken through an explicit fetch-hold handshake state machine; synchronous traps are handled directly. Vectored mtvec mode is supported. It drives the pipeline flush request and flush PC.

---
 rtl/lieat_exu_trap_ctrl_pkg.sv | 29 ++
 rtl/lieat_exu_trap_ctrl_if.sv | 37 +++
 rtl/lieat_irq_prio.sv | 18 +
 rtl/lieat_exu_trap_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/lieat_exu_trap_ctrl_pkg.sv
// Shared definitions for the EXU trap controller: CSR addresses, field positions,
// the synchronous cause code and the controller state encoding.
package lieat_exu_trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MTVEC_MODE_BIT   = 0;

  localparam int CAUSE_ECALL_M = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_TRAP = 2'd2
  } trap_state_e;

  function automatic logic is_csr_write(input logic valid, input logic write,
                                        input logic [11:0] idx, input logic [11:0] addr);
    return valid && write && (idx == addr);
  endfunction

endpackage

// File: rtl/lieat_exu_trap_ctrl_if.sv
// Commit-stage bundle between the pipeline (master) and the trap controller (slave).
interface lieat_exu_trap_ctrl_if #(
  parameter int XLEN    = 32,
  parameter int NUM_IRQ = 4
);
  logic              csr_valid;
  logic              csr_write;
  logic [11:0]       csr_idx;
  logic [XLEN-1:0]   csr_wdata;
  logic [XLEN-1:0]   csr_rdata;
  logic              ecall_valid;
  logic              mret_valid;
  logic [XLEN-1:0]   exc_pc;
  logic [NUM_IRQ-1:0] irq_lines;
  // Fetch hold handshake: if_hold_req stays high until fetch answers with
  // if_hold_rsp (transfer happens in a cycle where both are high) or the
  // controller withdraws it; if_hold_pc is meaningful only while if_hold_rsp is high.
  logic              if_hold_req;
  logic [XLEN-1:0]   if_hold_pc;
  logic              if_hold_rsp;
  logic              flush_req;
  logic [XLEN-1:0]   flush_pc;

  modport master (
    output csr_valid, csr_write, csr_idx, csr_wdata,
    output ecall_valid, mret_valid, exc_pc, irq_lines,
    output if_hold_pc, if_hold_rsp,
    input  csr_rdata, if_hold_req, flush_req, flush_pc
  );

  modport slave (
    input  csr_valid, csr_write, csr_idx, csr_wdata,
    input  ecall_valid, mret_valid, exc_pc, irq_lines,
    input  if_hold_pc, if_hold_rsp,
    output csr_rdata, if_hold_req, flush_req, flush_pc
  );
endinterface

// File: rtl/lieat_irq_prio.sv
// Lowest-index-wins priority encoder over the enabled, pending interrupt lines.
module lieat_irq_prio #(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               any,
  output logic [3:0]         idx
);

  always_comb begin
    any = |req;
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) idx = 4'(i);
    end
  end

endmodule

// File: rtl/lieat_exu_trap_ctrl.sv
// Machine trap CSRs plus the interrupt take sequence (IDLE -> HOLD -> TRAP) and
// the synchronous ecall/mret redirect path for the EXU commit stage.
module lieat_exu_trap_ctrl
  import lieat_exu_trap_ctrl_pkg::*;
#(
  parameter int              XLEN           = 32,
  parameter int              NUM_IRQ        = 4,
  parameter int              IRQ_BASE_CAUSE = 16,
  parameter logic [XLEN-1:0] MTVEC_RESET    = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  lieat_exu_trap_ctrl_if.slave  bus,
  output trap_state_e           state_dbg
);

  trap_state_e        state_q;
  logic               mstatus_mie;
  logic               mstatus_mpie;
  logic [NUM_IRQ-1:0] mie_q;
  logic [NUM_IRQ-1:0] mip_q;
  logic [XLEN-1:0]    mtvec_q;
  logic [XLEN-1:0]    mepc_q;
  logic [XLEN-1:0]    mcause_q;
  logic [3:0]         irq_idx_q;
  logic [XLEN-1:0]    hold_pc_q;
  logic               hold_req_q;
  logic               trap_flush_q;

  logic [NUM_IRQ-1:0] pend;
  logic               pend_any;
  logic [3:0]         pend_idx;
  logic               take;
  logic               sync_evt;
  logic               do_ecall;
  logic               do_mret;
  logic               do_trap;
  logic [NUM_IRQ-1:0] idx_mask;
  logic               latched_live;
  logic [XLEN-1:0]    trap_code;
  logic [XLEN-1:0]    mtvec_base;
  logic [XLEN-1:0]    trap_target;
  logic [XLEN-1:0]    rdata;
  logic [XLEN-1:0]    fpc;

  assign pend = mip_q & mie_q;

  lieat_irq_prio #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .req (pend),
    .any (pend_any),
    .idx (pend_idx)
  );

  assign take     = mstatus_mie & pend_any;
  assign sync_evt = bus.ecall_valid | bus.mret_valid;
  assign do_ecall = bus.ecall_valid;
  assign do_mret  = bus.mret_valid & ~bus.ecall_valid;
  // A sync trap committing in the TRAP cycle wins; the line stays pending in mip.
  assign do_trap  = trap_flush_q & ~sync_evt;

  assign idx_mask     = NUM_IRQ'(1) << irq_idx_q;
  assign latched_live = |(pend & idx_mask);

  assign trap_code   = XLEN'(IRQ_BASE_CAUSE) + XLEN'(irq_idx_q);
  assign mtvec_base  = {mtvec_q[XLEN-1:2], 2'b00};
  assign trap_target = mtvec_q[MTVEC_MODE_BIT] ? (mtvec_base + (trap_code << 2)) : mtvec_base;

  always_comb begin
    fpc = '0;
    if (do_ecall)          fpc = mtvec_base;
    else if (do_mret)      fpc = mepc_q;
    else if (trap_flush_q) fpc = trap_target;
  end

  assign bus.flush_req   = sync_evt | trap_flush_q;
  assign bus.flush_pc    = fpc;
  assign bus.if_hold_req = hold_req_q;
  assign state_dbg       = state_q;

  always_comb begin
    rdata = '0;
    case (bus.csr_idx)
      CSR_MSTATUS: begin
        rdata[MSTATUS_MIE_BIT]  = mstatus_mie;
        rdata[MSTATUS_MPIE_BIT] = mstatus_mpie;
      end
      CSR_MIE:    rdata[NUM_IRQ-1:0] = mie_q;
      CSR_MTVEC:  rdata = mtvec_q;
      CSR_MEPC:   rdata = mepc_q;
      CSR_MCAUSE: rdata = mcause_q;
      CSR_MIP:    rdata[NUM_IRQ-1:0] = mip_q;
      default:    rdata = '0;
    endcase
  end

  assign bus.csr_rdata = rdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_q        <= '0;
      mip_q        <= '0;
      mtvec_q      <= {MTVEC_RESET[XLEN-1:2], 1'b0, MTVEC_RESET[0]};
      mepc_q       <= '0;
      mcause_q     <= '0;
      irq_idx_q    <= '0;
      hold_pc_q    <= '0;
      hold_req_q   <= 1'b0;
      trap_flush_q <= 1'b0;
    end else begin
      mip_q <= bus.irq_lines;

      // Plain CSR writes first; trap/mret updates below override the same registers.
      if (is_csr_write(bus.csr_valid, bus.csr_write, bus.csr_idx, CSR_MSTATUS)) begin
        mstatus_mie  <= bus.csr_wdata[MSTATUS_MIE_BIT];
        mstatus_mpie <= bus.csr_wdata[MSTATUS_MPIE_BIT];
      end
      if (is_csr_write(bus.csr_valid, bus.csr_write, bus.csr_idx, CSR_MIE))
        mie_q <= bus.csr_wdata[NUM_IRQ-1:0];
      if (is_csr_write(bus.csr_valid, bus.csr_write, bus.csr_idx, CSR_MTVEC))
        mtvec_q <= {bus.csr_wdata[XLEN-1:2], 1'b0, bus.csr_wdata[0]};
      if (is_csr_write(bus.csr_valid, bus.csr_write, bus.csr_idx, CSR_MEPC))
        mepc_q <= {bus.csr_wdata[XLEN-1:2], 2'b00};
      if (is_csr_write(bus.csr_valid, bus.csr_write, bus.csr_idx, CSR_MCAUSE))
        mcause_q <= bus.csr_wdata;

      if (do_ecall) begin
        mepc_q       <= {bus.exc_pc[XLEN-1:2], 2'b00};
        mcause_q     <= XLEN'(CAUSE_ECALL_M);
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (do_mret) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (do_trap) begin
        mepc_q       <= {hold_pc_q[XLEN-1:2], 2'b00};
        mcause_q     <= {1'b1, trap_code[XLEN-2:0]};
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (take && !sync_evt) begin
            state_q    <= ST_HOLD;
            irq_idx_q  <= pend_idx;
            hold_req_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (sync_evt) begin
            state_q    <= ST_IDLE;
            hold_req_q <= 1'b0;
          end else if (bus.if_hold_rsp) begin
            state_q      <= ST_TRAP;
            hold_pc_q    <= bus.if_hold_pc;
            hold_req_q   <= 1'b0;
            trap_flush_q <= 1'b1;
          end else if (!latched_live || !mstatus_mie) begin
            state_q    <= ST_IDLE;
            hold_req_q <= 1'b0;
          end
        end
        ST_TRAP: begin
          state_q      <= ST_IDLE;
          trap_flush_q <= 1'b0;
        end
        default: begin
          state_q      <= ST_IDLE;
          hold_req_q   <= 1'b0;
          trap_flush_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
